// File: rtl/pulser_multi_if.sv
// Shared start/stop/config bus and per-channel pulse status for pulser_multi.
//   start/stop    : per-channel request strobes, sampled every rising edge
//   mode          : 00 one-shot, 01 burst, 10 continuous, 11 one-shot
//   period/width  : pulse period and high time in clock cycles
//   count         : pulses per burst (0 behaves as 1)
//   out/busy/done : per-channel registered pulse, activity flag, completion strobe
interface pulser_multi_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 24,
  parameter int unsigned BW  = 8
);
  logic [NCH-1:0] start;
  logic [NCH-1:0] stop;
  logic [1:0]     mode;
  logic [CW-1:0]  period;
  logic [CW-1:0]  width;
  logic [BW-1:0]  count;
  logic [NCH-1:0] out;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] done;

  modport master (
    output start, stop, mode, period, width, count,
    input  out, busy, done
  );

  modport slave (
    input  start, stop, mode, period, width, count,
    output out, busy, done
  );
endinterface

// File: rtl/pulser_multi.sv
// Multi-channel pulse generator: NCH independent IDLE/HIGH/LOW channels that
// each latch the shared config at start and emit one-shot, burst or
// continuous pulse trains.
//   clk : rising-edge clock
//   rst : synchronous active-high reset (aborts without a done strobe)
//   bus : pulser_multi_if slave (start/stop/config in, out/busy/done out)
module pulser_multi #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 24,
  parameter int unsigned BW  = 8
) (
  input  logic           clk,
  input  logic           rst,
  pulser_multi_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_HIGH = 2'b01,
    S_LOW  = 2'b10
  } state_e;

  state_e         state_q [NCH];
  state_e         state_d [NCH];
  logic [CW-1:0]  cnt_q   [NCH];   // cycles remaining in the current phase, minus one
  logic [CW-1:0]  cnt_d   [NCH];
  logic [CW-1:0]  hi_q    [NCH];   // latched high time
  logic [CW-1:0]  hi_d    [NCH];
  logic [CW-1:0]  lo_q    [NCH];   // latched low time
  logic [CW-1:0]  lo_d    [NCH];
  logic [BW-1:0]  left_q  [NCH];   // periods still to run, including the current one
  logic [BW-1:0]  left_d  [NCH];
  logic [NCH-1:0] cont_q, cont_d;
  logic [NCH-1:0] out_q,  out_d;
  logic [NCH-1:0] busy_q, busy_d;
  logic [NCH-1:0] done_q, done_d;

  logic [CW-1:0]  hi_c;
  logic [CW-1:0]  lo_c;
  logic [BW-1:0]  left_c;
  logic           cfg_ok_c;

  // High time is clipped to the period so the low time never underflows.
  assign hi_c     = (bus.width < bus.period) ? bus.width : bus.period;
  assign lo_c     = bus.period - hi_c;
  assign cfg_ok_c = (bus.period != '0) && (bus.width != '0);
  assign left_c   = (bus.mode == 2'b01) ? ((bus.count == '0) ? BW'(1) : bus.count)
                                        : BW'(1);

  // Next-state and output logic for every channel.
  always_comb begin
    cont_d = cont_q;
    out_d  = out_q;
    busy_d = busy_q;
    done_d = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      hi_d[i]    = hi_q[i];
      lo_d[i]    = lo_q[i];
      left_d[i]  = left_q[i];

      case (state_q[i])
        S_IDLE: begin
          if (bus.start[i] && !bus.stop[i] && cfg_ok_c) begin
            state_d[i] = S_HIGH;
            out_d[i]   = 1'b1;
            busy_d[i]  = 1'b1;
            hi_d[i]    = hi_c;
            lo_d[i]    = lo_c;
            cnt_d[i]   = hi_c - CW'(1);
            left_d[i]  = left_c;
            cont_d[i]  = (bus.mode == 2'b10);
          end
        end
        S_HIGH, S_LOW: begin
          if (bus.stop[i]) begin
            state_d[i] = S_IDLE;
            out_d[i]   = 1'b0;
            busy_d[i]  = 1'b0;
            done_d[i]  = 1'b1;
          end else if (cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - CW'(1);
          end else if ((state_q[i] == S_HIGH) && (lo_q[i] != '0)) begin
            state_d[i] = S_LOW;
            out_d[i]   = 1'b0;
            cnt_d[i]   = lo_q[i] - CW'(1);
          end else if (cont_q[i] || (left_q[i] > BW'(1))) begin
            // Period boundary with more periods to go: straight back to HIGH.
            if (!cont_q[i]) begin
              left_d[i] = left_q[i] - BW'(1);
            end
            state_d[i] = S_HIGH;
            out_d[i]   = 1'b1;
            cnt_d[i]   = hi_q[i] - CW'(1);
          end else begin
            state_d[i] = S_IDLE;
            out_d[i]   = 1'b0;
            busy_d[i]  = 1'b0;
            done_d[i]  = 1'b1;
          end
        end
        default: begin
          state_d[i] = S_IDLE;
          out_d[i]   = 1'b0;
          busy_d[i]  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NCH); i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
        hi_q[i]    <= '0;
        lo_q[i]    <= '0;
        left_q[i]  <= '0;
      end
      cont_q <= '0;
      out_q  <= '0;
      busy_q <= '0;
      done_q <= '0;
    end else begin
      for (int i = 0; i < int'(NCH); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        hi_q[i]    <= hi_d[i];
        lo_q[i]    <= lo_d[i];
        left_q[i]  <= left_d[i];
      end
      cont_q <= cont_d;
      out_q  <= out_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_pulser_multi.sv
// Scoreboard bench for pulser_multi: an arithmetic per-channel model predicts
// out/busy/done after every edge; a separate monitor pops and compares.
module tb_pulser_multi;

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 8;
  localparam int unsigned BW  = 4;

  typedef struct packed {
    logic [NCH-1:0] out;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] done;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pulser_multi_if #(.NCH(NCH), .CW(CW), .BW(BW)) bus ();

  pulser_multi #(.NCH(NCH), .CW(CW), .BW(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: a run is "elapsed active cycles e" against a total length.
  bit    m_act [NCH];
  longint m_e  [NCH];
  longint m_p  [NCH];
  longint m_h  [NCH];
  longint m_n  [NCH];   // number of periods; 0 means run until stopped

  // Evaluate the model for the edge happening now and queue the expectation.
  task automatic model_step();
    exp_t   x;
    longint p, w, h, n;
    x = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (rst) begin
        m_act[i] = 1'b0;
      end else if (m_act[i]) begin
        if (bus.stop[i]) begin
          m_act[i]  = 1'b0;
          x.done[i] = 1'b1;
        end else begin
          m_e[i] = m_e[i] + 1;
          if (m_n[i] != 0 && m_e[i] == m_p[i] * m_n[i]) begin
            m_act[i]  = 1'b0;
            x.done[i] = 1'b1;
          end else begin
            x.busy[i] = 1'b1;
            x.out[i]  = ((m_e[i] % m_p[i]) < m_h[i]);
          end
        end
      end else if (bus.start[i] && !bus.stop[i]) begin
        p = longint'(bus.period);
        w = longint'(bus.width);
        if (p != 0 && w != 0) begin
          h = (w < p) ? w : p;
          case (bus.mode)
            2'b01:   n = (bus.count == 0) ? 1 : longint'(bus.count);
            2'b10:   n = 0;
            default: n = 1;
          endcase
          m_act[i]  = 1'b1;
          m_e[i]    = 0;
          m_p[i]    = p;
          m_h[i]    = h;
          m_n[i]    = n;
          x.busy[i] = 1'b1;
          x.out[i]  = 1'b1;
        end
      end
    end
    sb_q.push_back(x);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic set_cfg(input int mode, input int p, input int w, input int c);
    bus.mode   = 2'(mode);
    bus.period = CW'(p);
    bus.width  = CW'(w);
    bus.count  = BW'(c);
  endtask

  task automatic start_ch(input logic [NCH-1:0] mask, input int mode,
                          input int p, input int w, input int c);
    set_cfg(mode, p, w, c);
    bus.start = mask;
    step();
    bus.start = '0;
  endtask

  // Monitor: compare DUT outputs against the queued expectation away from the edge.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        a = '{out: bus.out, busy: bus.busy, done: bus.done};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL edge_check t=%0t got out=%b busy=%b done=%b want out=%b busy=%b done=%b",
                   $time, a.out, a.busy, a.done, e.out, e.busy, e.done);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < int'(NCH); i++) begin
      m_act[i] = 1'b0;
      m_e[i] = 0; m_p[i] = 1; m_h[i] = 0; m_n[i] = 1;
    end
    rst       = 1'b1;
    bus.start = '0;
    bus.stop  = '0;
    set_cfg(0, 0, 0, 0);
    step(3);
    rst = 1'b0;

    // One-shot 10/3.
    start_ch(4'h1, 0, 10, 3, 0);
    step(13);
    // Burst 4/1 x3, then COUNT=0.
    start_ch(4'h1, 1, 4, 1, 3);
    step(14);
    start_ch(4'h1, 1, 4, 1, 0);
    step(6);
    // Continuous 5/5, stopped.
    start_ch(4'h1, 2, 5, 5, 0);
    step(12);
    bus.stop = 4'h1;
    step();
    bus.stop = '0;
    step(3);
    // Degenerate configs are ignored.
    start_ch(4'h1, 0, 0, 3, 0);
    step(2);
    start_ch(4'h1, 0, 5, 0, 0);
    step(2);
    // Width larger than period, burst of 2; mode 11 as one-shot.
    start_ch(4'h1, 1, 6, 8, 2);
    step(14);
    start_ch(4'h2, 3, 3, 1, 0);
    step(5);
    // Stop in idle, and start+stop together in idle.
    bus.stop = 4'hF;
    step();
    set_cfg(0, 4, 2, 0);
    bus.start = 4'hF;
    step();
    bus.start = '0;
    bus.stop  = '0;
    step(2);
    // All channels together, config changed mid-run, start while busy,
    // restart in the done cycle.
    start_ch(4'hF, 1, 7, 2, 3);
    set_cfg(0, 2, 1, 0);
    step(5);
    start_ch(4'h2, 2, 3, 1, 0);
    step(14);
    start_ch(4'hF, 0, 3, 2, 0);
    step(5);
    // Reset mid-burst with start held, then immediate start.
    start_ch(4'hF, 1, 3, 1, 5);
    step(6);
    rst       = 1'b1;
    bus.start = 4'hF;
    step();
    rst       = 1'b0;
    bus.start = '0;
    start_ch(4'h1, 0, 4, 2, 0);
    step(6);
    // Full-length counters.
    start_ch(4'h1, 0, 255, 100, 0);
    step(257);
    start_ch(4'h4, 1, 2, 1, 15);
    step(32);

    // Randomised traffic.
    for (int t = 0; t < 3000; t++) begin
      bus.start = '0;
      bus.stop  = '0;
      for (int i = 0; i < int'(NCH); i++) begin
        bus.start[i] = ($urandom_range(0, 5) == 0);
        bus.stop[i]  = ($urandom_range(0, 40) == 0);
      end
      if ($urandom_range(0, 3) == 0)
        set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
                int'($urandom_range(0, 14)), int'($urandom_range(0, 5)));
      rst = ($urandom_range(0, 600) == 0);
      step();
    end
    rst       = 1'b0;
    bus.start = '0;
    bus.stop  = '0;
    step(3);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
